// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: round-robin ranging of three HC-SR04 sensors into 12-bit cm distances
module hcsr04_ranger #(
  parameter int TRIG_CYC    = 500,
  parameter int CYC_PER_CM  = 2900,
  parameter int ECHO_TO_CYC = 1500000,
  parameter int GAP_CYC     = 3000000,
  parameter int MAX_CM      = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  echo,
  output logic [2:0]  trig,
  output logic [11:0] sens1,
  output logic [11:0] sens2,
  output logic [11:0] sens3,
  output logic [2:0]  timeout,
  output logic        frame_valid,
  output logic        busy
);
  localparam logic [2:0] IDLE = 3'd0, TRIG = 3'd1, WAIT_RISE = 3'd2, MEASURE = 3'd3, GAP = 3'd4;
  localparam int TM1 = ECHO_TO_CYC > TRIG_CYC ? ECHO_TO_CYC : TRIG_CYC;
  localparam int TMAX = GAP_CYC > TM1 ? GAP_CYC : TM1;
  localparam int TW = $clog2(TMAX + 1);
  localparam int PW = CYC_PER_CM > 1 ? $clog2(CYC_PER_CM) : 1;
  logic [2:0] state, echo_m, echo_s;
  logic [1:0] idx;
  logic [TW-1:0] timer;
  logic [PW-1:0] pre;
  logic [11:0] cm, res;
  logic sel, tick, pre_wrap, t_echo, done, to_flag;
  always_comb begin
    sel = echo_s[idx];
    tick = (state == WAIT_RISE || state == MEASURE) && sel;
    pre_wrap = pre == PW'(CYC_PER_CM - 1);
    t_echo = timer == TW'(ECHO_TO_CYC - 1);
    done = (state == WAIT_RISE && !sel && t_echo) || (state == MEASURE && (!sel || t_echo));
    to_flag = state == WAIT_RISE || sel;
    res = to_flag ? 12'(MAX_CM) : cm;
    trig = state == TRIG ? 3'b001 << idx : 3'b000;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx <= 2'd0;
      timer <= '0;
      pre <= '0;
      cm <= 12'd0;
      echo_m <= 3'd0;
      echo_s <= 3'd0;
      sens1 <= 12'd0;
      sens2 <= 12'd0;
      sens3 <= 12'd0;
      timeout <= 3'd0;
      frame_valid <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      frame_valid <= 1'b0;
      if (tick) begin
        pre <= pre_wrap ? '0 : pre + 1'b1;
        if (pre_wrap && cm < 12'(MAX_CM)) cm <= cm + 1'b1;
      end
      if (done) begin
        if (idx == 2'd0) sens1 <= res;
        if (idx == 2'd1) sens2 <= res;
        if (idx == 2'd2) sens3 <= res;
        timeout[idx] <= to_flag;
      end
      case (state)
        IDLE: if (enable) begin
          state <= TRIG;
          idx <= 2'd0;
          timer <= '0;
          pre <= '0;
          cm <= 12'd0;
        end
        TRIG: begin
          state <= timer == TW'(TRIG_CYC - 1) ? WAIT_RISE : TRIG;
          timer <= timer == TW'(TRIG_CYC - 1) ? '0 : timer + 1'b1;
        end
        WAIT_RISE: begin
          state <= sel ? MEASURE : done ? GAP : WAIT_RISE;
          timer <= sel || done ? '0 : timer + 1'b1;
        end
        MEASURE: begin
          state <= done ? GAP : MEASURE;
          timer <= done ? '0 : timer + 1'b1;
        end
        GAP: if (timer == TW'(GAP_CYC - 1)) begin
          timer <= '0;
          pre <= '0;
          cm <= 12'd0;
          state <= idx == 2'd2 ? IDLE : TRIG;
          idx <= idx == 2'd2 ? idx : idx + 1'b1;
          frame_valid <= idx == 2'd2;
        end else timer <= timer + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: directed-vector bench for hcsr04_ranger with scaled-down timing
module tb_hcsr04_ranger;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [2:0] echo = 3'd0, trig, timeout;
  logic [11:0] sens1, sens2, sens3;
  logic frame_valid, busy;
  logic [2:0] prev = 3'd0;
  int n_vec = 0, n_bad = 0, overlap = 0, fv_cnt = 0;
  int ev[$];
  always #5 clk = ~clk;
  hcsr04_ranger #(
    .TRIG_CYC(3), .CYC_PER_CM(4), .ECHO_TO_CYC(2000), .GAP_CYC(10), .MAX_CM(400)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .sens1(sens1), .sens2(sens2), .sens3(sens3), .timeout(timeout),
    .frame_valid(frame_valid), .busy(busy)
  );
  always @(negedge clk) begin
    if ($countones(trig) > 1) overlap++;
    if (trig != 3'd0 && trig != prev) ev.push_back(trig[0] ? 0 : trig[1] ? 1 : 2);
    prev = trig;
    if (frame_valid) fv_cnt++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sens_of(input int i);
    return i == 0 ? int'(sens1) : i == 1 ? int'(sens2) : int'(sens3);
  endfunction
  task automatic wait_trig(input int i);
    int n = 0;
    while (!trig[i] && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("trig%0d_rise", i), int'(trig[i]), 1);
    n = 0;
    while (trig[i] && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("trig%0d_width", i), n, 3);
  endtask
  task automatic pulse(input int i, input int dly, input int w, input int exp_cm);
    wait_trig(i);
    repeat (dly) @(posedge clk);
    #1 echo[i] = 1'b1;
    repeat (w) @(posedge clk);
    #1 echo[i] = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk($sformatf("sens%0d_dist", i + 1), sens_of(i), exp_cm);
    chk($sformatf("timeout%0d_clr", i), int'(timeout[i]), 0);
  endtask
  task automatic no_echo(input int i, input int side);
    int n = 0;
    wait_trig(i);
    while (!timeout[i] && n < 2100) begin
      echo[side] = n < 30;
      @(posedge clk);
      #1 n++;
    end
    echo[side] = 1'b0;
    chk($sformatf("rise_to%0d_cycles", i), n, 2000);
    chk($sformatf("sens%0d_rise_to", i + 1), sens_of(i), 400);
    chk($sformatf("timeout%0d_set", i), int'(timeout[i]), 1);
  endtask
  task automatic stuck(input int i);
    int n = 0;
    wait_trig(i);
    repeat (2) @(posedge clk);
    #1 echo[i] = 1'b1;
    while (!timeout[i] && n < 2100) begin
      @(posedge clk);
      #1 n++;
    end
    echo[i] = 1'b0;
    chk($sformatf("meas_to%0d_cycles", i), n, 2003);
    chk($sformatf("sens%0d_meas_to", i + 1), sens_of(i), 400);
    chk($sformatf("timeout%0d_set", i), int'(timeout[i]), 1);
  endtask
  task automatic start_frame();
    int n = 0;
    enable = 1'b1;
    while (!busy && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    enable = 1'b0;
    chk("start_busy", int'(busy), 1);
  endtask
  task automatic end_frame(input int f0);
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("fv_pulse", int'(frame_valid), 1);
    @(posedge clk);
    #1 chk("fv_drop", int'(frame_valid), 0);
    chk("idle_busy", int'(busy), 0);
    chk("fv_count", fv_cnt - f0, 1);
  endtask
  initial begin
    int s, f;
    repeat (3) @(posedge clk);
    #1 chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sens1", int'(sens1), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_fv", int'(frame_valid), 0);
    reset = 1'b1;
    @(posedge clk);
    #1 s = ev.size();
    f = fv_cnt;
    start_frame();
    pulse(0, 5, 40, 10);
    pulse(1, 5, 43, 10);
    pulse(2, 5, 3, 0);
    chk("fv_early", fv_cnt - f, 0);
    end_frame(f);
    chk("trig_events", ev.size() - s, 3);
    chk("order0", ev.size() > s ? ev[s] : -1, 0);
    chk("order1", ev.size() > s + 1 ? ev[s + 1] : -1, 1);
    chk("order2", ev.size() > s + 2 ? ev[s + 2] : -1, 2);
    f = fv_cnt;
    start_frame();
    no_echo(0, 1);
    chk("sens2_hold", int'(sens2), 10);
    chk("sens3_hold", int'(sens3), 0);
    stuck(1);
    chk("sens1_hold", int'(sens1), 400);
    pulse(2, 5, 20, 5);
    end_frame(f);
    start_frame();
    pulse(0, 5, 8, 2);
    wait_trig(1);
    repeat (5) @(posedge clk);
    #1 echo[1] = 1'b1;
    repeat (50) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 chk("abort_trig", int'(trig), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sens1", int'(sens1), 0);
    chk("abort_sens2", int'(sens2), 0);
    chk("abort_sens3", int'(sens3), 0);
    chk("abort_timeout", int'(timeout), 0);
    chk("abort_fv", int'(frame_valid), 0);
    reset = 1'b1;
    echo[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 s = ev.size();
    f = fv_cnt;
    start_frame();
    pulse(0, 3, 12, 3);
    chk("restart_first", ev.size() > s ? ev[s] : -1, 0);
    pulse(1, 3, 16, 4);
    pulse(2, 3, 4, 1);
    end_frame(f);
    chk("trig_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
